// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - built-in self-test driver/checker for the 8-bit alu
//
// Drives the alu operand/instruction interface with LFSR operands, sweeping
// all eight instructions N_PER_INST vectors each, and checks the returned
// result/overflow LAT cycles later against an internal golden model.
//
// Ports:
//   clk_p_i          clock, rising edge
//   reset_p_i        synchronous active-high reset
//   start_i          start pulse, honoured in IDLE or DONE only
//   alu_a_o/alu_b_o  operands to the alu (two's complement)
//   alu_inst_o       instruction code to the alu
//   alu_data_i       alu result
//   alu_ovf_i        alu overflow flag
//   busy_o           high while issuing vectors or draining the check pipe
//   done_o           high once the run has completed
//   pass_o           valid with done_o; 1 iff no mismatches
//   err_cnt_o        saturating mismatch count
//
// Optional feature macro ALU_BIST_ERR_LOG_EN adds first_err_* outputs that
// capture the first failing vector of a run.

module alu_bist #(
    parameter int          N_PER_INST = 100,
    parameter int          LAT        = 2,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic        clk_p_i,
    input  logic        reset_p_i,
    input  logic        start_i,
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    output logic [2:0]  alu_inst_o,
    input  logic [7:0]  alu_data_i,
    input  logic        alu_ovf_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] err_cnt_o
`ifdef ALU_BIST_ERR_LOG_EN
    ,
    output logic        first_err_vld_o,
    output logic [2:0]  first_err_inst_o,
    output logic [7:0]  first_err_a_o,
    output logic [7:0]  first_err_b_o,
    output logic [7:0]  first_err_data_o,
    output logic        first_err_ovf_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [15:0] lfsr;
    logic [15:0] lfsr_step;
    logic [9:0]  vec_cnt;
    logic [2:0]  drain_cnt;
    // High during every cycle in which the operand outputs carry an issued vector.
    logic        vec_vld;

    logic        start_run;
    logic        last_vec;
    logic        drain_end;

    logic signed [16:0] ae;
    logic signed [16:0] be;
    logic signed [16:0] e;
    logic               e_ovf;

    logic        pipe_vld  [LAT];
    logic [7:0]  pipe_data [LAT];
    logic        pipe_ovf  [LAT];

    logic        chk;
    logic        fail;
    logic [15:0] err_next;

    assign start_run = start_i && (state == S_IDLE || state == S_DONE);
    assign last_vec  = (alu_inst_o == 3'd7) && (vec_cnt == 10'(N_PER_INST - 1));
    assign drain_end = (drain_cnt == 3'(LAT - 1));

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    assign lfsr_step = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    assign busy_o = (state == S_RUN) || (state == S_DRAIN);
    assign done_o = (state == S_DONE);

    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start_i)   state_n = S_RUN;
            S_RUN:   if (last_vec)  state_n = S_DRAIN;
            S_DRAIN: if (drain_end) state_n = S_DONE;
            S_DONE:  if (start_i)   state_n = S_RUN;
            default: state_n = S_IDLE;
        endcase
    end

    // Golden model evaluated on the registered vector the alu currently sees,
    // so it enters the pipe one cycle after issue and leaves after LAT stages,
    // aligned with the alu result.
    assign ae = {{9{alu_a_o[7]}}, alu_a_o};
    assign be = {{9{alu_b_o[7]}}, alu_b_o};

    always_comb begin
        e = ae + be;
        case (alu_inst_o)
            3'd0: e = ae + be;
            3'd1: e = be - ae;
            3'd2: e = ae * be;
            3'd3: e = ae & be;
            3'd4: e = ae ^ be;
            3'd5: e = (ae < 0) ? -ae : ae;
            3'd6: e = (ae + be) >>> 1;
            3'd7: e = (ae > be) ? ae : be;
            default: e = ae + be;
        endcase
    end

    assign e_ovf = (e > 17'sd127) || (e < -17'sd128);

    assign chk  = pipe_vld[LAT-1];
    // On expected overflow only the flag matters; otherwise flag and data must match.
    assign fail = chk && (pipe_ovf[LAT-1] ? !alu_ovf_i
                                          : (alu_ovf_i || (alu_data_i != pipe_data[LAT-1])));
    assign err_next = (fail && err_cnt_o != 16'hFFFF) ? err_cnt_o + 16'd1 : err_cnt_o;

    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            lfsr       <= SEED;
            alu_a_o    <= '0;
            alu_b_o    <= '0;
            alu_inst_o <= '0;
            vec_cnt    <= '0;
            drain_cnt  <= '0;
            vec_vld    <= 1'b0;
            pass_o     <= 1'b0;
            err_cnt_o  <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_data[i] <= '0;
                pipe_ovf[i]  <= 1'b0;
            end
        end else begin
            pipe_vld[0]  <= vec_vld;
            pipe_data[0] <= e[7:0];
            pipe_ovf[0]  <= e_ovf;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
                pipe_ovf[i]  <= pipe_ovf[i-1];
            end

            err_cnt_o <= start_run ? 16'd0 : err_next;

            if (start_run) begin
                alu_a_o    <= lfsr[7:0];
                alu_b_o    <= lfsr[15:8];
                alu_inst_o <= 3'd0;
                vec_cnt    <= '0;
                lfsr       <= lfsr_step;
                vec_vld    <= 1'b1;
                pass_o     <= 1'b0;
            end else if (state == S_RUN) begin
                if (last_vec) begin
                    // Operands hold the last vector through the drain.
                    vec_vld   <= 1'b0;
                    drain_cnt <= '0;
                end else begin
                    alu_a_o <= lfsr[7:0];
                    alu_b_o <= lfsr[15:8];
                    lfsr    <= lfsr_step;
                    if (vec_cnt == 10'(N_PER_INST - 1)) begin
                        vec_cnt    <= '0;
                        alu_inst_o <= alu_inst_o + 3'd1;
                    end else begin
                        vec_cnt <= vec_cnt + 10'd1;
                    end
                end
            end else if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + 3'd1;
                if (drain_end) begin
                    pass_o <= (err_next == 16'd0);
                end
            end
        end
    end

`ifdef ALU_BIST_ERR_LOG_EN
    logic [7:0] pipe_a    [LAT];
    logic [7:0] pipe_b    [LAT];
    logic [2:0] pipe_inst [LAT];

    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_a[i]    <= '0;
                pipe_b[i]    <= '0;
                pipe_inst[i] <= '0;
            end
            first_err_vld_o  <= 1'b0;
            first_err_inst_o <= '0;
            first_err_a_o    <= '0;
            first_err_b_o    <= '0;
            first_err_data_o <= '0;
            first_err_ovf_o  <= 1'b0;
        end else begin
            pipe_a[0]    <= alu_a_o;
            pipe_b[0]    <= alu_b_o;
            pipe_inst[0] <= alu_inst_o;
            for (int i = 1; i < LAT; i++) begin
                pipe_a[i]    <= pipe_a[i-1];
                pipe_b[i]    <= pipe_b[i-1];
                pipe_inst[i] <= pipe_inst[i-1];
            end
            if (start_run) begin
                first_err_vld_o  <= 1'b0;
                first_err_inst_o <= '0;
                first_err_a_o    <= '0;
                first_err_b_o    <= '0;
                first_err_data_o <= '0;
                first_err_ovf_o  <= 1'b0;
            end else if (fail && !first_err_vld_o) begin
                first_err_vld_o  <= 1'b1;
                first_err_inst_o <= pipe_inst[LAT-1];
                first_err_a_o    <= pipe_a[LAT-1];
                first_err_b_o    <= pipe_b[LAT-1];
                first_err_data_o <= alu_data_i;
                first_err_ovf_o  <= alu_ovf_i;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_bist.sv
// tb/tb_alu_bist.sv - directed self-checking bench for alu_bist

module tb_alu_bist;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_inst;
    logic [7:0]  alu_data;
    logic        alu_ovf;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

    // Behavioural alu with two register stages; mode selects an injected fault.
    logic [8:0] g_now;
    logic [8:0] alu_in;
    logic [8:0] s1 = '0;
    logic [8:0] s2 = '0;

    always #5 clk = ~clk;

    alu_bist #(.N_PER_INST(100), .LAT(2), .SEED(16'hACE1)) dut (
        .clk_p_i    (clk),
        .reset_p_i  (reset),
        .start_i    (start),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_inst_o (alu_inst),
        .alu_data_i (alu_data),
        .alu_ovf_i  (alu_ovf),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .err_cnt_o  (err_cnt)
    );

    function automatic logic [8:0] gold(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int sa;
        int sb;
        int r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: r = sa + sb;
            3'd1: r = sb - sa;
            3'd2: r = sa * sb;
            3'd3: r = sa & sb;
            3'd4: r = sa ^ sb;
            3'd5: r = (sa < 0) ? -sa : sa;
            3'd6: r = (sa + sb) >>> 1;
            default: r = (sa > sb) ? sa : sb;
        endcase
        return {(r > 127 || r < -128), r[7:0]};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    endfunction

    assign g_now = gold(alu_a, alu_b, alu_inst);

    always_comb begin
        alu_in = g_now;
        if (mode == 1 && alu_inst == 3'd3) alu_in[0] = ~alu_in[0];
        if (mode == 2) alu_in[8] = 1'b0;
    end

    always @(posedge clk) begin
        s1 <= alu_in;
        s2 <= s1;
    end

    assign alu_data = s2[7:0];
    assign alu_ovf  = s2[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles from the current negedge; optionally pulses start at
    // two chosen busy cycles and checks the instruction sweep boundaries.
    task automatic run_measure(input int inj1, input int inj2, input bit chk_inst, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 2000) begin
            cycles++;
            if (chk_inst && cycles == 100) check("inst_before_switch", 32'(alu_inst), 32'd0);
            if (chk_inst && cycles == 101) check("inst_after_switch", 32'(alu_inst), 32'd1);
            if (chk_inst && cycles == 801) check("inst_hold_drain", 32'(alu_inst), 32'd7);
            start = (cycles == inj1) || (cycles == inj2);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int          cyc;
        int          exp_ovf_cnt;
        logic [15:0] l;
        logic [8:0]  g;

        // Expected overflow count of the first 800 vectors from SEED.
        exp_ovf_cnt = 0;
        l = 16'hACE1;
        for (int i = 0; i < 800; i++) begin
            g = gold(l[7:0], l[15:8], 3'(i / 100));
            if (g[8]) exp_ovf_cnt++;
            l = lfsr_next(l);
        end

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_a", 32'(alu_a), 32'd0);
        check("rst_b", 32'(alu_b), 32'd0);
        check("rst_inst", 32'(alu_inst), 32'd0);

        // Clean run, with start pulses in RUN and DRAIN that must be ignored.
        mode = 0;
        pulse_start();
        check("run1_first_a", 32'(alu_a), 32'hE1);
        check("run1_first_b", 32'(alu_b), 32'hAC);
        check("run1_first_inst", 32'(alu_inst), 32'd0);
        check("run1_busy", 32'(busy), 32'd1);
        run_measure(100, 801, 1'b1, cyc);
        check("run1_cycles", 32'(cyc), 32'd802);
        check("run1_done", 32'(done), 32'd1);
        check("run1_pass", 32'(pass), 32'd1);
        check("run1_err", 32'(err_cnt), 32'd0);

        // Bit 0 inverted on instruction 011 only.
        mode = 1;
        pulse_start();
        check("run2_done_clr", 32'(done), 32'd0);
        run_measure(0, 0, 1'b0, cyc);
        check("run2_cycles", 32'(cyc), 32'd802);
        check("run2_err", 32'(err_cnt), 32'd100);
        check("run2_pass", 32'(pass), 32'd0);
        check("run2_done", 32'(done), 32'd1);

        // Start from DONE clears the count and begins a fresh run.
        mode = 0;
        pulse_start();
        check("run3_err_clr", 32'(err_cnt), 32'd0);
        check("run3_done_clr", 32'(done), 32'd0);
        check("run3_busy", 32'(busy), 32'd1);
        run_measure(0, 0, 1'b0, cyc);
        check("run3_cycles", 32'(cyc), 32'd802);
        check("run3_err", 32'(err_cnt), 32'd0);
        check("run3_pass", 32'(pass), 32'd1);

        // Reset in the middle of a run.
        mode = 2;
        pulse_start();
        repeat (350) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_pass", 32'(pass), 32'd0);
        check("mid_rst_err", 32'(err_cnt), 32'd0);
        check("mid_rst_a", 32'(alu_a), 32'd0);
        check("mid_rst_b", 32'(alu_b), 32'd0);
        check("mid_rst_inst", 32'(alu_inst), 32'd0);

        // Restart from SEED; the alu never raises overflow.
        pulse_start();
        check("run4_first_a", 32'(alu_a), 32'hE1);
        check("run4_first_b", 32'(alu_b), 32'hAC);
        @(negedge clk);
        l = lfsr_next(16'hACE1);
        check("run4_second_a", 32'(alu_a), 32'(l[7:0]));
        check("run4_second_b", 32'(alu_b), 32'(l[15:8]));
        run_measure(0, 0, 1'b0, cyc);
        check("run4_cycles", 32'(cyc), 32'd801);
        check("run4_err", 32'(err_cnt), 32'(exp_ovf_cnt));
        check("run4_pass", 32'(pass), 32'(exp_ovf_cnt == 0));
        check("run4_done", 32'(done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
